counter_run_controller: RTL and testbench
=========================================

// Module: counter_run_controller
// PURPOSE
//  Sequences the board's 4-bit LED counter from the single system clock.
//  Replaces the derived slow clock with a 1-cycle count-enable tick from an internal prescaler.
//  Decodes start/stop/step buttons into a RUN/PAUSE/IDLE/DONE run-state machine.
//  Drives the external synchronous counter's enable, direction and clear, and reads back its value.
//  Sits between the debounced/synchronised KEY inputs and the LED counter.
// PARAMETERS
//  TICK_DIV  5_000_000  clk cycles per count tick in RUN (10 Hz at 50 MHz); legal range >= 2
//  CNT_W     4          width of the external counter value
// PORTS
//  clk        in   1      system clock; only clock in the block
//  reset      in   1      synchronous, active-high; wins over every other input
//  btn_start  in   1      start/resume; level, pre-synchronised; acts on rising edge
//  btn_stop   in   1      pause/abort; level, pre-synchronised; acts on rising edge
//  btn_step   in   1      single step; level, pre-synchronised; acts on rising edge
//  dir_down   in   1      1 = count down, 0 = count up
//  mode_oneshot in 1      1 = stop at terminal count, 0 = free-run with wrap
//  count_in   in   CNT_W  current value of the external counter
//  cnt_en     out  1      1-cycle pulse: counter steps once
//  cnt_up     out  1      direction to counter (registered ~dir_down)
//  cnt_clr    out  1      1-cycle pulse: counter loads 0 if cnt_up, all-ones if down
//  state      out  2      IDLE=00 RUN=01 PAUSE=10 DONE=11
//  done       out  1      high while state==DONE
// BEHAVIOUR
//  Reset values: state=IDLE, cnt_en=0, cnt_clr=0, cnt_up=1, done=0, prescaler=0.
//  On reset, button-history registers are set to 1: a button held through reset fires nothing.
//  Edge detection: event = btn & ~btn_prev. All outputs are registered.
//  - Outputs change on the same clk edge that first samples the button high.
//  Simultaneous edges:
//  - stop beats start and step; start beats step.
//  - Each button edge produces at most one action.
//  IDLE:
//  - start -> RUN; cnt_clr=1 for one cycle; prescaler=0.
//  - step -> cnt_en=1 for one cycle; stay IDLE.
//  - stop -> no-op.
//  RUN:
//  - Prescaler counts 0..TICK_DIV-1, then wraps.
//  - The tick is the cycle the prescaler equals TICK_DIV-1. The first tick comes TICK_DIV cycles after entry.
//  - On a tick, assert cnt_en for exactly one cycle, except in the oneshot case below.
//  - stop -> PAUSE; prescaler holds its value.
//  - start and step are ignored.
//  PAUSE:
//  - start -> RUN; prescaler resumes from the held value (no restart).
//  - step -> one cnt_en pulse; stay PAUSE.
//  - stop -> IDLE with one cnt_clr pulse.
//  Oneshot (mode_oneshot=1):
//  - At a RUN tick, compare count_in with terminal = all-ones if cnt_up, 0 if down.
//  - If equal: no cnt_en; go to DONE; done=1; prescaler cleared.
//  - mode_oneshot=0: never enters DONE; the counter wraps naturally.
//  DONE:
//  - start -> RUN with cnt_clr pulse.
//  - stop -> IDLE.
//  - step ignored; done deasserts on exit.
//  cnt_up follows dir_down with 1 cycle latency in every state.
//  - A direction change in RUN applies to the next tick.
//  cnt_en and cnt_clr are never high in the same cycle.
//  Reset mid-RUN or mid-PAUSE: next cycle is IDLE; no cnt_en or cnt_clr pulse.
// TESTING (TICK_DIV=4, CNT_W=4, model counter on the bench)
//  1. Reset, start edge -> cnt_clr 1 cycle, state=01; cnt_en every 4th cycle; count 0,1,2..F,0.
//  2. RUN, stop after 2 prescaler cycles -> state=10, no cnt_en; start -> first tick 2 cycles later.
//  3. oneshot=1 up, start -> 15 cnt_en pulses, count=F, next tick: no cnt_en, state=11, done=1.
//  4. dir_down=1, oneshot=1, start -> clr loads F; 15 ticks to 0; then DONE.
//  5. start and stop edges same cycle in IDLE, then in RUN -> stays IDLE; goes PAUSE.
//  6. btn_start held high through reset -> no action.
//     Reset asserted mid-RUN -> IDLE, all outputs at reset values, no stray pulses.
//  7. step in IDLE and in PAUSE -> exactly one cnt_en each.
//     step in RUN and in DONE -> nothing.

Source files
------------

// File: rtl/counter_run_controller.sv
// counter_run_controller: run/pause/step sequencer for an external LED counter, clocked from the single system clock
//   clk, reset         system clock; synchronous active-high reset
//   btn_start/stop/step  synchronised button levels; each acts on its rising edge
//   dir_down, mode_oneshot  count direction; stop at the terminal count instead of wrapping
//   count_in           value read back from the external counter
//   cnt_en, cnt_clr    1-cycle step / clear pulses to the counter
//   cnt_up             registered direction to the counter
//   state, done        run state (IDLE=00 RUN=01 PAUSE=10 DONE=11); high while DONE
module counter_run_controller #(
   parameter int TICK_DIV = 5_000_000,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_start,
   input  logic             btn_stop,
   input  logic             btn_step,
   input  logic             dir_down,
   input  logic             mode_oneshot,
   input  logic [CNT_W-1:0] count_in,
   output logic             cnt_en,
   output logic             cnt_up,
   output logic             cnt_clr,
   output logic [1:0]       state,
   output logic             done
);
   localparam int PW = $clog2(TICK_DIV);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_e;
   state_e          state_q, state_d;
   logic [PW-1:0]   psc_q, psc_d;
   logic [2:0]      prev_q;
   logic            cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d, cnt_up_q, done_q;
   logic            ev_start, ev_stop, ev_step, tick, finish;
   // history resets to ones so a button held through reset never fires
   assign ev_start = btn_start & ~prev_q[2];
   assign ev_stop  = btn_stop  & ~prev_q[1];
   assign ev_step  = btn_step  & ~prev_q[0];
   assign tick     = (state_q == RUN) && (psc_q == PW'(TICK_DIV - 1));
   // terminal count depends on the direction the counter is currently stepping in
   assign finish   = tick && mode_oneshot && (count_in == {CNT_W{cnt_up_q}});
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         psc_q     <= '0;
         prev_q    <= 3'b111;
         cnt_en_q  <= 1'b0;
         cnt_clr_q <= 1'b0;
         cnt_up_q  <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         psc_q     <= psc_d;
         prev_q    <= {btn_start, btn_stop, btn_step};
         cnt_en_q  <= cnt_en_d;
         cnt_clr_q <= cnt_clr_d;
         cnt_up_q  <= ~dir_down;
         done_q    <= (state_d == DONE);
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        state_d = (ev_start && !ev_stop) ? RUN : IDLE;
         RUN:         state_d = ev_stop ? PAUSE : finish ? DONE : RUN;
         PAUSE, DONE: state_d = ev_stop ? IDLE : ev_start ? RUN : state_q;
      endcase
   end
   // stop outranks start, start outranks step; a stop on a tick cycle swallows the tick
   always_comb begin
      cnt_en_d  = 1'b0;
      cnt_clr_d = 1'b0;
      psc_d     = psc_q;
      case (state_q)
         IDLE: begin
            cnt_en_d  = ev_step && !ev_start && !ev_stop;
            cnt_clr_d = ev_start && !ev_stop;
            psc_d     = '0;
         end
         RUN: begin
            cnt_en_d = tick && !ev_stop && !finish;
            psc_d    = ev_stop ? psc_q : tick ? '0 : psc_q + PW'(1);
         end
         PAUSE: begin
            cnt_en_d  = ev_step && !ev_start && !ev_stop;
            cnt_clr_d = ev_stop;
            psc_d     = ev_stop ? '0 : psc_q;
         end
         DONE: begin
            cnt_clr_d = ev_start && !ev_stop;
            psc_d     = '0;
         end
      endcase
   end
   assign cnt_en  = cnt_en_q;
   assign cnt_clr = cnt_clr_q;
   assign cnt_up  = cnt_up_q;
   assign state   = state_q;
   assign done    = done_q;
endmodule

// File: tb/tb_counter_run_controller.sv
// tb_counter_run_controller: directed checks of the run controller against a model LED counter
module tb_counter_run_controller;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_start = 1'b0, btn_stop = 1'b0, btn_step = 1'b0;
   logic       dir_down = 1'b0, mode_oneshot = 1'b0;
   logic [3:0] cnt = 4'h0;
   logic       cnt_en, cnt_up, cnt_clr, done;
   logic [1:0] state;
   int         checks = 0, errors = 0, en_pulses = 0, p;

   counter_run_controller #(.TICK_DIV(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop), .btn_step(btn_step),
      .dir_down(dir_down), .mode_oneshot(mode_oneshot), .count_in(cnt),
      .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr(cnt_clr), .state(state), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cnt_clr) cnt <= cnt_up ? 4'h0 : 4'hF;
      else if (cnt_en) cnt <= cnt_up ? cnt + 4'h1 : cnt - 4'h1;
      if (cnt_en === 1'b1) en_pulses <= en_pulses + 1;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      cyc(2);
      chk("rst_state", 32'(state), 0);
      chk("rst_en", 32'(cnt_en), 0);
      chk("rst_clr", 32'(cnt_clr), 0);
      chk("rst_up", 32'(cnt_up), 1);
      chk("rst_done", 32'(done), 0);
      reset = 1'b0;
      cyc(1);
      // free-running up count with wrap
      btn_start = 1'b1;
      cyc(1);
      chk("t1_state", 32'(state), 1);
      chk("t1_clr", 32'(cnt_clr), 1);
      chk("t1_en", 32'(cnt_en), 0);
      btn_start = 1'b0;
      cyc(1);
      chk("t1_clr_off", 32'(cnt_clr), 0);
      chk("t1_cnt0", 32'(cnt), 0);
      for (int k = 1; k <= 16; k++) begin
         cyc(2);
         chk("t1_gap", 32'(cnt_en), 0);
         cyc(1);
         chk("t1_tick", 32'(cnt_en), 1);
         cyc(1);
         chk("t1_cnt", 32'(cnt), 32'(k % 16));
      end
      chk("t1_pulses", 32'(en_pulses), 16);
      // pause holding prescaler at 2, resume ticks two cycles later
      cyc(1);
      btn_stop = 1'b1;
      cyc(1);
      chk("t2_pause", 32'(state), 2);
      chk("t2_en", 32'(cnt_en), 0);
      btn_stop = 1'b0;
      p = en_pulses;
      cyc(5);
      chk("t2_quiet", 32'(en_pulses), 32'(p));
      btn_start = 1'b1;
      cyc(1);
      chk("t2_resume", 32'(state), 1);
      chk("t2_noclr", 32'(cnt_clr), 0);
      btn_start = 1'b0;
      cyc(1);
      chk("t2_early", 32'(cnt_en), 0);
      cyc(1);
      chk("t2_tick", 32'(cnt_en), 1);
      cyc(1);
      chk("t2_cnt", 32'(cnt), 1);
      btn_stop = 1'b1;
      cyc(1);
      chk("t2_pause2", 32'(state), 2);
      btn_stop = 1'b0;
      cyc(1);
      btn_stop = 1'b1;
      cyc(1);
      chk("t2_idle", 32'(state), 0);
      chk("t2_clr", 32'(cnt_clr), 1);
      btn_stop = 1'b0;
      cyc(1);
      chk("t2_cleared", 32'(cnt), 0);
      // step in IDLE
      btn_step = 1'b1;
      cyc(1);
      chk("t7_idle_en", 32'(cnt_en), 1);
      chk("t7_idle_st", 32'(state), 0);
      cyc(1);
      chk("t7_idle_once", 32'(cnt_en), 0);
      chk("t7_idle_cnt", 32'(cnt), 1);
      btn_step = 1'b0;
      // oneshot up
      mode_oneshot = 1'b1;
      btn_start = 1'b1;
      cyc(1);
      chk("t3_clr", 32'(cnt_clr), 1);
      btn_start = 1'b0;
      cyc(1);
      chk("t3_cnt0", 32'(cnt), 0);
      for (int k = 1; k <= 15; k++) begin
         cyc(3);
         chk("t3_tick", 32'(cnt_en), 1);
         cyc(1);
         chk("t3_cnt", 32'(cnt), 32'(k));
      end
      cyc(3);
      chk("t3_noen", 32'(cnt_en), 0);
      chk("t3_state", 32'(state), 3);
      chk("t3_done", 32'(done), 1);
      p = en_pulses;
      cyc(4);
      chk("t3_hold", 32'(state), 3);
      btn_step = 1'b1;
      cyc(1);
      chk("t7_done_en", 32'(cnt_en), 0);
      chk("t7_done_st", 32'(state), 3);
      btn_step = 1'b0;
      cyc(1);
      chk("t3_nopulse", 32'(en_pulses), 32'(p));
      btn_stop = 1'b1;
      cyc(1);
      chk("t3_idle", 32'(state), 0);
      chk("t3_done_off", 32'(done), 0);
      chk("t3_noclr", 32'(cnt_clr), 0);
      btn_stop = 1'b0;
      // oneshot down
      dir_down = 1'b1;
      chk("t4_up_lat", 32'(cnt_up), 1);
      cyc(1);
      chk("t4_up", 32'(cnt_up), 0);
      btn_start = 1'b1;
      cyc(1);
      chk("t4_clr", 32'(cnt_clr), 1);
      btn_start = 1'b0;
      cyc(1);
      chk("t4_cntF", 32'(cnt), 15);
      for (int k = 1; k <= 15; k++) begin
         cyc(3);
         chk("t4_tick", 32'(cnt_en), 1);
         cyc(1);
         chk("t4_cnt", 32'(cnt), 32'(15 - k));
      end
      cyc(3);
      chk("t4_noen", 32'(cnt_en), 0);
      chk("t4_state", 32'(state), 3);
      chk("t4_done", 32'(done), 1);
      // DONE restart, step ignored in RUN, simultaneous edges
      btn_start = 1'b1;
      cyc(1);
      chk("t4_restart", 32'(state), 1);
      chk("t4_reclr", 32'(cnt_clr), 1);
      chk("t4_done_off", 32'(done), 0);
      btn_start = 1'b0;
      btn_step = 1'b1;
      cyc(1);
      chk("t7_run_en", 32'(cnt_en), 0);
      chk("t7_run_st", 32'(state), 1);
      btn_step = 1'b0;
      cyc(1);
      btn_start = 1'b1;
      btn_stop = 1'b1;
      cyc(1);
      chk("t5_run_both", 32'(state), 2);
      btn_start = 1'b0;
      btn_stop = 1'b0;
      cyc(1);
      btn_step = 1'b1;
      cyc(1);
      chk("t7_pause_en", 32'(cnt_en), 1);
      chk("t7_pause_st", 32'(state), 2);
      btn_step = 1'b0;
      cyc(1);
      chk("t7_pause_once", 32'(cnt_en), 0);
      chk("t7_pause_cnt", 32'(cnt), 14);
      btn_stop = 1'b1;
      cyc(1);
      chk("t4_idle", 32'(state), 0);
      chk("t4_idle_clr", 32'(cnt_clr), 1);
      btn_stop = 1'b0;
      cyc(1);
      chk("t4_clrF", 32'(cnt), 15);
      btn_start = 1'b1;
      btn_stop = 1'b1;
      cyc(1);
      chk("t5_idle_both", 32'(state), 0);
      chk("t5_idle_clr", 32'(cnt_clr), 0);
      chk("t5_idle_en", 32'(cnt_en), 0);
      btn_start = 1'b0;
      btn_stop = 1'b0;
      // reset behaviour
      dir_down = 1'b0;
      mode_oneshot = 1'b0;
      btn_start = 1'b1;
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(3);
      chk("t6_held_st", 32'(state), 0);
      chk("t6_held_clr", 32'(cnt_clr), 0);
      btn_start = 1'b0;
      cyc(1);
      btn_start = 1'b1;
      cyc(1);
      chk("t6_run", 32'(state), 1);
      btn_start = 1'b0;
      cyc(2);
      p = en_pulses;
      reset = 1'b1;
      cyc(1);
      chk("t6_rst_st", 32'(state), 0);
      chk("t6_rst_en", 32'(cnt_en), 0);
      chk("t6_rst_clr", 32'(cnt_clr), 0);
      chk("t6_rst_up", 32'(cnt_up), 1);
      chk("t6_rst_done", 32'(done), 0);
      reset = 1'b0;
      cyc(6);
      chk("t6_after_st", 32'(state), 0);
      chk("t6_after_en", 32'(en_pulses), 32'(p));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
